fifo_write_arbiter: RTL and testbench

- Shares the single write port of the 2048x64 event FIFO among NUM_CH requesting channels (per-channel event builders).
- Uses round-robin arbitration and a one-word-per-cycle write stream.
- Drives the FIFO's active-low write strobe and data bus from registers, and applies backpressure from the FIFO fill level.
- No event is dropped: a channel keeps its request pending until it is granted.

---
 rtl/fifo_write_arbiter_pkg.sv | 18 +
 rtl/fifo_write_arbiter_if.sv | 35 +++
 rtl/fifo_write_arbiter_rr_select.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the event FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        BLOCKED = 2'd2
    } arb_state_t;

    localparam int NUM_CH_DEF     = 4;
    localparam int FIFO_WIDTH_DEF = 64;
    localparam int FIFO_DEPTH_DEF = 2048;
    localparam int FIFO_BITS_DEF  = 11;
    localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Bundle of request channels and FIFO write port seen by the arbiter.
// Latency: n/a (wires only).
// Backpressure: fifo_counter carries FIFO occupancy back to the arbiter.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_BITS    = 2,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_BITS  = FIFO_BITS_DEF
) ();

    logic                         enable;
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH*FIFO_WIDTH-1:0] ch_data;
    logic [FIFO_BITS:0]           fifo_counter;
    logic [NUM_CH-1:0]            grant;
    logic [FIFO_WIDTH-1:0]        fifo_data;
    logic                         fifo_write_n;
    logic [CH_BITS-1:0]           last_ch;
    logic                         busy;

    // Arbiter side: consumes requests and fill level, drives the FIFO write port.
    modport master (
        input  enable, req, ch_data, fifo_counter,
        output grant, fifo_data, fifo_write_n, last_ch, busy
    );

    // Channel/FIFO side: the mirror image.
    modport slave (
        output enable, req, ch_data, fifo_counter,
        input  grant, fifo_data, fifo_write_n, last_ch, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Round-robin pick: first set req bit searching from last_ch+1, wrapping.
// Latency: combinational.
// Backpressure: none; vld low when no channel requests.
module rr_select #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] last_ch,
    output logic [CH_BITS-1:0] winner,
    output logic               vld
);

    // Walk the channels after last_ch so the previous winner has lowest priority.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        vld    = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_ch) + k) % NUM_CH;
            if (!vld && req[idx]) begin
                vld    = 1'b1;
                winner = CH_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; optional FIFO_ARB_STALL_CNT_EN adds a stall counter.
// Latency: grant and fifo_write_n follow a request by one cycle; one word per cycle while streaming.
// Backpressure: holds off (BLOCKED) while fifo_counter >= FIFO_DEPTH-2; requests wait, none dropped.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_BITS    = 2,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_BITS  = FIFO_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
`ifdef FIFO_ARB_STALL_CNT_EN
    input  logic                    stall_clr,
    output logic [STALL_CNT_W-1:0]  stall_count,
`endif
    fifo_write_arbiter_if.master    bus
);

    // One word of headroom covers the write still in flight when the counter is sampled.
    localparam logic [FIFO_BITS:0] SPACE_LIMIT = (FIFO_BITS+1)'(FIFO_DEPTH - 2);

    arb_state_t             state;
    logic [NUM_CH-1:0]      req_masked;
    logic [CH_BITS-1:0]     winner;
    logic                   pending;
    logic                   space_ok;
    logic                   take;
    logic                   block;
    logic [FIFO_WIDTH-1:0]  sel_dat;

    // The channel granted this cycle still shows req until it sees the grant.
    assign req_masked = bus.req & ~bus.grant;
    assign space_ok   = (bus.fifo_counter < SPACE_LIMIT);

    rr_select #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_select (
        .req     (req_masked),
        .last_ch (bus.last_ch),
        .winner  (winner),
        .vld     (pending)
    );

    // Same write condition from every state; WRITE may fall into BLOCKED even with enable low.
    assign take  = bus.enable & pending & space_ok;
    assign block = pending & ~space_ok & (bus.enable | (state == WRITE));

    // Mux the winning channel's word onto the write data path.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner == CH_BITS'(i)) begin
                sel_dat = bus.ch_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Arbitration FSM with registered write strobe, data, grant and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.grant        <= '0;
            bus.fifo_data    <= '0;
            bus.fifo_write_n <= 1'b1;
            bus.last_ch      <= CH_BITS'(NUM_CH - 1);
            bus.busy         <= 1'b0;
        end else begin
            bus.grant        <= '0;
            bus.fifo_write_n <= 1'b1;
            bus.busy         <= 1'b0;
            if (take) begin
                state            <= WRITE;
                bus.grant        <= {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
                bus.fifo_data    <= sel_dat;
                bus.fifo_write_n <= 1'b0;
                bus.last_ch      <= winner;
                bus.busy         <= 1'b1;
            end else if (block) begin
                state <= BLOCKED;
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // Saturating count of BLOCKED cycles; a clear wins over a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_clr) begin
            stall_count <= '0;
        end else if ((state == BLOCKED) && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: cycle-by-cycle vector table plus reset and stall sequences.
module tb_fifo_write_arbiter;

    logic clk;
    logic reset_n;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic        stall_clr;
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_write_arbiter_if #(
        .NUM_CH(4), .CH_BITS(2), .FIFO_WIDTH(64), .FIFO_BITS(11)
    ) bus ();

    fifo_write_arbiter #(
        .NUM_CH(4), .CH_BITS(2), .FIFO_WIDTH(64), .FIFO_DEPTH(2048), .FIFO_BITS(11)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_clr   (stall_clr),
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [11:0] cnt;
        logic [3:0]  g;
        logic        wn;
        logic        busy;
        logic [1:0]  last;
    } vec_t;

    vec_t vt[$];

    function automatic logic [63:0] word(int i);
        return {32'hA5A5_0000 + 32'(i), 32'h1234_5670 + 32'(i)};
    endfunction

    task automatic add(input logic rst, input logic en, input logic [3:0] req,
                       input logic [11:0] cnt, input logic [3:0] g, input logic wn,
                       input logic busy, input logic [1:0] last);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.cnt = cnt;
        v.g = g; v.wn = wn; v.busy = busy; v.last = last;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " grant"},   64'(bus.grant), 64'h0);
        chk({tag, " data"},    bus.fifo_data, 64'h0);
        chk({tag, " write_n"}, 64'(bus.fifo_write_n), 64'h1);
        chk({tag, " last_ch"}, 64'(bus.last_ch), 64'h3);
        chk({tag, " busy"},    64'(bus.busy), 64'h0);
    endtask

    // Watchdog: the bench only waits on its own clock, but never let it run away.
    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout actual=expired required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.req          = '0;
        bus.fifo_counter = 12'd1;
        for (int i = 0; i < 4; i++) bus.ch_data[i*64 +: 64] = word(i);
`ifdef FIFO_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif

        // Basic single request, then the granted channel still high is masked.
        add(0, 1, 4'b0001,   1, 4'b0001, 0, 1, 0);
        add(0, 1, 4'b0001,   1, 4'b0000, 1, 0, 0);
        add(0, 1, 4'b0000,   1, 4'b0000, 1, 0, 0);
        // All four request; requesters drop one cycle after grant and re-raise one later.
        add(1, 1, 4'b1111, 100, 4'b0001, 0, 1, 0);
        add(0, 1, 4'b1111, 100, 4'b0010, 0, 1, 1);
        add(0, 1, 4'b1110, 100, 4'b0100, 0, 1, 2);
        add(0, 1, 4'b1101, 100, 4'b1000, 0, 1, 3);
        add(0, 1, 4'b1011, 100, 4'b0001, 0, 1, 0);
        add(0, 1, 4'b0000, 100, 4'b0000, 1, 0, 0);
        // Space boundary: 2046 blocks, 2045 still writes (full flag sits at 2047).
        add(1, 1, 4'b0001, 2046, 4'b0000, 1, 0, 3);
        add(0, 1, 4'b0001, 2046, 4'b0000, 1, 0, 3);
        add(0, 1, 4'b0001, 2045, 4'b0001, 0, 1, 0);
        add(0, 1, 4'b0011, 2046, 4'b0000, 1, 0, 0);
        add(0, 1, 4'b0010, 2045, 4'b0010, 0, 1, 1);
        add(0, 1, 4'b0000, 2045, 4'b0000, 1, 0, 1);
        add(0, 1, 4'b0100, 2047, 4'b0000, 1, 0, 1);
        add(0, 0, 4'b0100, 2047, 4'b0000, 1, 0, 1);
        add(0, 1, 4'b0100,    5, 4'b0100, 0, 1, 2);
        add(0, 1, 4'b0000,    5, 4'b0000, 1, 0, 2);
        // Enable dropped mid-stream, then a withdrawn request is skipped.
        add(1, 1, 4'b1111, 10, 4'b0001, 0, 1, 0);
        add(0, 1, 4'b1111, 10, 4'b0010, 0, 1, 1);
        add(0, 0, 4'b1110, 10, 4'b0000, 1, 0, 1);
        add(0, 0, 4'b1110, 10, 4'b0000, 1, 0, 1);
        add(0, 1, 4'b1000, 10, 4'b1000, 0, 1, 3);
        add(0, 1, 4'b0000, 10, 4'b0000, 1, 0, 3);

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        foreach (vt[n]) begin
            if (vt[n].rst) apply_reset();
            bus.enable       = vt[n].en;
            bus.req          = vt[n].req;
            bus.fifo_counter = vt[n].cnt;
            tick();
            chk($sformatf("vec%0d grant", n),   64'(bus.grant), 64'(vt[n].g));
            chk($sformatf("vec%0d write_n", n), 64'(bus.fifo_write_n), 64'(vt[n].wn));
            chk($sformatf("vec%0d busy", n),    64'(bus.busy), 64'(vt[n].busy));
            chk($sformatf("vec%0d last_ch", n), 64'(bus.last_ch), 64'(vt[n].last));
            if (!vt[n].wn) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (vt[n].g[i]) idx = i;
                chk($sformatf("vec%0d data", n), bus.fifo_data, word(idx));
            end
        end

        // Reset in the middle of a write clears everything without waiting for a clock.
        bus.enable = 1'b0;
        bus.req    = '0;
        tick();
        apply_reset();
        bus.enable       = 1'b1;
        bus.req          = 4'b0010;
        bus.fifo_counter = 12'd1;
        tick();
        chk("midrst pre grant",   64'(bus.grant), 64'h2);
        chk("midrst pre write_n", 64'(bus.fifo_write_n), 64'h0);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("midrst async");
        @(negedge clk);
        reset_n = 1'b1;
        bus.req = 4'b0011;
        tick();
        chk("midrst post grant",   64'(bus.grant), 64'h1);
        chk("midrst post data",    bus.fifo_data, word(0));
        chk("midrst post last_ch", 64'(bus.last_ch), 64'h0);
        bus.req = '0;
        tick();

`ifdef FIFO_ARB_STALL_CNT_EN
        // Park in BLOCKED long enough to saturate, then clear while still blocked.
        apply_reset();
        bus.enable       = 1'b1;
        bus.req          = 4'b0001;
        bus.fifo_counter = 12'd2047;
        tick();
        chk("stall first", 64'(stall_count), 64'h0);
        tick();
        chk("stall one", 64'(stall_count), 64'h1);
        repeat (70000) tick();
        chk("stall sat", 64'(stall_count), 64'hFFFF);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("stall clr", 64'(stall_count), 64'h0);
        tick();
        chk("stall resume", 64'(stall_count), 64'h1);
        bus.req = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
